pixel_packer: RTL and testbench

- Downstream neighbour of the brightness stage: consumes its 8-bit processed pixel stream, one pixel per accepted beat.
- Packs four consecutive pixels into a 32-bit word for the frame-store/VGA writer.
- Tracks frame position and flags the final (possibly partial) word of each frame.
- Provides valid/ready backpressure on both sides through a small word FIFO.

---
 rtl/img_pkg.sv | 39 +++
 rtl/pixel_packer_if.sv | 38 +++
 rtl/word_fifo.sv | 95 +++++++++
 rtl/pixel_packer.sv | 134 +++++++++++++
 tb/tb_pixel_packer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared image-pipeline definitions used by the brightness stage and the
// pixel packer: pixel/word geometry, default frame size, the packed word FIFO
// entry, the packer FSM state type and the final-word keep-mask helper.
// -----------------------------------------------------------------------------
package img_pkg;

    localparam int PIX_W      = 8;
    localparam int WORD_W     = 32;
    localparam int LANES      = 4;

    localparam int DEF_WIDTH  = 361;
    localparam int DEF_HEIGHT = 410;

    // One queued output word: pixel lanes, byte-valid mask, end-of-frame flag.
    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [LANES-1:0]  keep;
        logic              last;
    } fifo_entry_t;

    typedef enum logic {
        ST_PACK  = 1'b0,
        ST_DRAIN = 1'b1
    } pack_state_t;

    // Keep mask of the last word in a frame: the low (pixels mod LANES) lanes,
    // or all lanes when the frame divides evenly into words.
    function automatic logic [LANES-1:0] final_keep(input int unsigned frame_pixels);
        int unsigned n;
        n = frame_pixels % LANES;
        if (n == 0) begin
            return '1;
        end
        return LANES'((32'd1 << n) - 32'd1);
    endfunction

endpackage

// File: rtl/pixel_packer_if.sv
// -----------------------------------------------------------------------------
// pixel_packer_if
// Bus bundle around the pixel packer.
//   pix_valid/pix_data/pix_ready        : 8-bit pixel stream in
//   word_valid/word_data/word_keep/
//   word_last/word_ready                : 32-bit packed word stream out
//   frame_done/frame_count              : frame completion status
// Modport slave is the packer side, master is the surrounding system.
// -----------------------------------------------------------------------------
interface pixel_packer_if;
    import img_pkg::*;

    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_ready;

    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic [LANES-1:0]  word_keep;
    logic              word_last;
    logic              word_ready;

    logic              frame_done;
    logic [15:0]       frame_count;

    modport slave (
        input  pix_valid, pix_data, word_ready,
        output pix_ready, word_valid, word_data, word_keep, word_last,
               frame_done, frame_count
    );

    modport master (
        output pix_valid, pix_data, word_ready,
        input  pix_ready, word_valid, word_data, word_keep, word_last,
               frame_done, frame_count
    );

endinterface

// File: rtl/word_fifo.sv
// -----------------------------------------------------------------------------
// word_fifo
// Synchronous FIFO with registered head outputs and async active-high reset.
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_din (caller never pushes while o_full)
//   i_din     : entry to write
//   i_pop     : consume the head entry (ignored while empty)
//   o_valid   : head entry present
//   o_dout    : head entry, registered; zero while empty
//   o_full    : all DEPTH entries occupied
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_dout,
    output logic         o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic [W-1:0]     r_dout;

    logic             w_pop;
    logic [PTR_W-1:0] w_rd_next;

    assign w_pop     = i_pop & r_valid;
    assign w_rd_next = r_rd_ptr + 1'b1;

    // NOTE: storage array is deliberately not reset; only pointers/count/head are.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_dout   <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end

            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Head register tracks the oldest entry. On a pop the successor is
            // either already in storage or is the word being pushed right now.
            if (w_pop) begin
                if (r_count > CNT_W'(1)) begin
                    r_dout  <= r_mem[w_rd_next];
                    r_valid <= 1'b1;
                end else if (i_push) begin
                    r_dout  <= i_din;
                    r_valid <= 1'b1;
                end else begin
                    r_dout  <= '0;
                    r_valid <= 1'b0;
                end
            end else if (!r_valid && i_push) begin
                r_dout  <= i_din;
                r_valid <= 1'b1;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_dout  = r_dout;
    assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/pixel_packer.sv
// -----------------------------------------------------------------------------
// pixel_packer
// Packs four consecutive 8-bit pixels into a 32-bit word (first pixel in
// [7:0]), tracks frame position, marks the final (possibly partial) word of
// each frame and queues words in a small FIFO with valid/ready on both sides.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pixel_packer_if.slave
//              pix_valid/pix_data/pix_ready  pixel input stream
//              word_valid/word_data/word_keep/word_last/word_ready  output words
//              frame_done  one-cycle pulse after the last word is accepted
//              frame_count completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module pixel_packer
    import img_pkg::*;
#(
    parameter  int WIDTH        = DEF_WIDTH,
    parameter  int HEIGHT       = DEF_HEIGHT,
    parameter  int FIFO_DEPTH   = 4,
    localparam int FRAME_PIXELS = WIDTH * HEIGHT
) (
    input  logic           clk,
    input  logic           rst,
    pixel_packer_if.slave  bus
);

    localparam int                CNT_W     = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam int                IDX_W     = $clog2(LANES);
    localparam logic [LANES-1:0]  LAST_KEEP = final_keep(FRAME_PIXELS);

    pack_state_t       r_state;
    logic [CNT_W-1:0]  r_pix_cnt;
    logic [IDX_W-1:0]  r_byte_idx;
    logic [WORD_W-1:0] r_asm;
    logic              r_frame_done;
    logic [15:0]       r_frame_count;

    logic              w_accept;
    logic              w_last_pix;
    logic              w_complete;
    logic              w_pop;
    logic              w_fifo_valid;
    logic              w_fifo_full;
    logic [WORD_W-1:0] w_word;
    fifo_entry_t       w_push_entry;
    fifo_entry_t       w_head;

    // Ready depends only on registered state (and reset), never on word_ready.
    assign bus.pix_ready = ~rst & (r_state == ST_PACK) & ~w_fifo_full;

    assign w_accept   = bus.pix_valid & bus.pix_ready;
    assign w_last_pix = (r_pix_cnt == CNT_W'(FRAME_PIXELS - 1));
    assign w_complete = w_accept & ((r_byte_idx == IDX_W'(LANES - 1)) | w_last_pix);
    assign w_pop      = w_fifo_valid & bus.word_ready;

    // Lanes above byte_idx in r_asm are always zero, so the word being built
    // is just the assembly register with the current lane filled in.
    // NOTE: every combinational output gets a full default before partial updates.
    always_comb begin
        w_word = r_asm;
        w_word[r_byte_idx * PIX_W +: PIX_W] = bus.pix_data;
    end

    always_comb begin
        w_push_entry.data = w_word;
        w_push_entry.keep = w_last_pix ? LAST_KEEP : '1;
        w_push_entry.last = w_last_pix;
    end

    // Packing datapath: byte lane index, assembly register, frame pixel counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt  <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_byte_idx <= '0;
                r_asm      <= '0;
            end else begin
                r_byte_idx <= r_byte_idx + 1'b1;
                r_asm      <= w_word;
            end
            r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
        end
    end

    // DRAIN blocks the next frame until its predecessor's last word has left,
    // so no new pixel can land in a word queued behind the frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_PACK;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_PACK: begin
                    if (w_accept && w_last_pix) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && w_head.last) begin
                        r_state       <= ST_PACK;
                        r_frame_done  <= 1'b1;
                        r_frame_count <= r_frame_count + 1'b1;
                    end
                end
            endcase
        end
    end

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fifo_entry_t))
    ) u_word_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_complete),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_dout  (w_head),
        .o_full  (w_fifo_full)
    );

    assign bus.word_valid  = w_fifo_valid;
    assign bus.word_data   = w_head.data;
    assign bus.word_keep   = w_head.keep;
    assign bus.word_last   = w_head.last;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_pixel_packer.sv
// -----------------------------------------------------------------------------
// tb_pixel_packer
// Directed bench for pixel_packer. Three instances share clock and reset:
//   u_a : 3x2 frame, FIFO depth 4
//   u_b : 4x2 frame, FIFO depth 2
//   u_c : 7x3 frame, FIFO depth 4 (21 pixels -> last keep 0001)
// -----------------------------------------------------------------------------
module tb_pixel_packer;
    import img_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pixel_packer_if bus_a ();
    pixel_packer_if bus_b ();
    pixel_packer_if bus_c ();

    pixel_packer #(.WIDTH(3), .HEIGHT(2)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    pixel_packer #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(2)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    pixel_packer #(.WIDTH(7), .HEIGHT(3)) u_c (
        .clk (clk),
        .rst (rst),
        .bus (bus_c.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pixels 0x01..0x06 back-to-back into u_a with word_ready held high.
    task automatic a_frame_direct(input string pfx);
        bus_a.word_ready = 1'b1;
        bus_a.pix_valid  = 1'b1;
        bus_a.pix_data   = 8'h01; tick();
        bus_a.pix_data   = 8'h02; tick();
        bus_a.pix_data   = 8'h03; tick();
        bus_a.pix_data   = 8'h04; tick();
        check({pfx, "_w0_valid"}, bus_a.word_valid, 1'b1);
        check({pfx, "_w0_data"},  bus_a.word_data, 32'h04030201);
        check({pfx, "_w0_keep"},  bus_a.word_keep, 4'b1111);
        check({pfx, "_w0_last"},  bus_a.word_last, 1'b0);
        bus_a.pix_data   = 8'h05; tick();
        check({pfx, "_gap_valid"}, bus_a.word_valid, 1'b0);
        bus_a.pix_data   = 8'h06; tick();
        check({pfx, "_w1_valid"}, bus_a.word_valid, 1'b1);
        check({pfx, "_w1_data"},  bus_a.word_data, 32'h00000605);
        check({pfx, "_w1_keep"},  bus_a.word_keep, 4'b0011);
        check({pfx, "_w1_last"},  bus_a.word_last, 1'b1);
        check({pfx, "_drain_ready"}, bus_a.pix_ready, 1'b0);
        check({pfx, "_fd_early"}, bus_a.frame_done, 1'b0);
        bus_a.pix_valid  = 1'b0;
        tick();
        check({pfx, "_fd_pulse"}, bus_a.frame_done, 1'b1);
        check({pfx, "_fcount"},   bus_a.frame_count, 16'd1);
        check({pfx, "_empty"},    bus_a.word_valid, 1'b0);
        check({pfx, "_ready_back"}, bus_a.pix_ready, 1'b1);
        tick();
        check({pfx, "_fd_single"}, bus_a.frame_done, 1'b0);
    endtask

    initial begin
        logic                acc;
        int                  acc_cnt;
        logic [PIX_W-1:0]    pix   [42];
        logic [WORD_W-1:0]   e_dat [12];
        logic [LANES-1:0]    e_kp  [12];
        logic                e_lst [12];
        int                  pi;
        int                  wi;
        int                  cyc;
        int                  fd;
        int                  k;

        bus_a.pix_valid = 1'b0; bus_a.pix_data = '0; bus_a.word_ready = 1'b0;
        bus_b.pix_valid = 1'b0; bus_b.pix_data = '0; bus_b.word_ready = 1'b0;
        bus_c.pix_valid = 1'b0; bus_c.pix_data = '0; bus_c.word_ready = 1'b0;

        // Keep-mask helper: default frame 148010 pixels, and 21 pixels.
        check("keep_fn_default", final_keep(DEF_WIDTH * DEF_HEIGHT), 4'b0011);
        check("keep_fn_21",      final_keep(21), 4'b0001);

        // ---- Reset state ----
        rst = 1'b1;
        #2;
        check("rst_ready_low", bus_a.pix_ready, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_word_valid", bus_a.word_valid, 1'b0);
        check("rst_word_data",  bus_a.word_data, 32'h0);
        check("rst_word_keep",  bus_a.word_keep, 4'h0);
        check("rst_word_last",  bus_a.word_last, 1'b0);
        check("rst_frame_done", bus_a.frame_done, 1'b0);
        check("rst_frame_cnt",  bus_a.frame_count, 16'd0);
        check("rst_ready_high", bus_a.pix_ready, 1'b1);

        // ---- Scenario 1: back-to-back 3x2 frame ----
        a_frame_direct("s1");

        // ---- Scenario 2: word_ready low for 20 cycles, pix_valid held ----
        bus_a.word_ready = 1'b0;
        bus_a.pix_valid  = 1'b1;
        bus_a.pix_data   = 8'h11;
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            acc = bus_a.pix_valid & bus_a.pix_ready;
            tick();
            if (acc) begin
                acc_cnt++;
                bus_a.pix_data = bus_a.pix_data + 8'h01;
            end
        end
        check("s2_accepted", acc_cnt, 6);
        check("s2_stall_ready", bus_a.pix_ready, 1'b0);
        check("s2_head_hold", bus_a.word_data, 32'h14131211);
        check("s2_head_last", bus_a.word_last, 1'b0);
        bus_a.word_ready = 1'b1;
        tick();
        check("s2_w1_data", bus_a.word_data, 32'h00001615);
        check("s2_w1_keep", bus_a.word_keep, 4'b0011);
        check("s2_w1_last", bus_a.word_last, 1'b1);
        check("s2_still_drain", bus_a.pix_ready, 1'b0);
        tick();
        check("s2_fd_pulse", bus_a.frame_done, 1'b1);
        check("s2_fcount", bus_a.frame_count, 16'd2);
        check("s2_ready_back", bus_a.pix_ready, 1'b1);
        bus_a.pix_valid = 1'b0;
        tick();

        // ---- Scenario 4: reset after 5 of 6 pixels ----
        bus_a.word_ready = 1'b0;
        bus_a.pix_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_a.pix_data = 8'h21 + 8'(i);
            tick();
        end
        check("s4_queued", bus_a.word_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("s4_async_valid", bus_a.word_valid, 1'b0);
        check("s4_async_data",  bus_a.word_data, 32'h0);
        check("s4_async_ready", bus_a.pix_ready, 1'b0);
        check("s4_async_fcnt",  bus_a.frame_count, 16'd0);
        bus_a.pix_valid = 1'b0;
        tick();
        check("s4_no_fd_rst", bus_a.frame_done, 1'b0);
        rst = 1'b0;
        tick();
        check("s4_no_fd_after", bus_a.frame_done, 1'b0);
        check("s4_empty_after", bus_a.word_valid, 1'b0);
        a_frame_direct("s4");

        // ---- Scenario 3: 4x2 frame, FIFO depth 2, word_ready low ----
        bus_b.word_ready = 1'b0;
        bus_b.pix_valid  = 1'b1;
        bus_b.pix_data   = 8'h31;
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            acc = bus_b.pix_valid & bus_b.pix_ready;
            tick();
            if (acc) begin
                acc_cnt++;
                bus_b.pix_data = bus_b.pix_data + 8'h01;
            end
        end
        check("s3_accepted", acc_cnt, 8);
        check("s3_full_ready", bus_b.pix_ready, 1'b0);
        check("s3_head0", bus_b.word_data, 32'h34333231);
        bus_b.word_ready = 1'b1;
        tick();
        check("s3_head1", bus_b.word_data, 32'h38373635);
        check("s3_head1_keep", bus_b.word_keep, 4'b1111);
        check("s3_head1_last", bus_b.word_last, 1'b1);
        check("s3_drain_ready", bus_b.pix_ready, 1'b0);
        bus_b.word_ready = 1'b0;
        tick();
        check("s3_drain_hold", bus_b.pix_ready, 1'b0);
        check("s3_no_fd", bus_b.frame_done, 1'b0);
        bus_b.word_ready = 1'b1;
        tick();
        check("s3_fd_pulse", bus_b.frame_done, 1'b1);
        check("s3_fcount", bus_b.frame_count, 16'd1);
        check("s3_ready_back", bus_b.pix_ready, 1'b1);
        check("s3_empty", bus_b.word_valid, 1'b0);
        bus_b.pix_valid  = 1'b0;
        bus_b.word_ready = 1'b0;

        // ---- Scenario 5: two 7x3 frames with random handshakes ----
        for (int i = 0; i < 42; i++) begin
            pix[i] = 8'((i * 37 + 5) & 8'hFF);
        end
        k = 0;
        for (int f = 0; f < 2; f++) begin
            for (int base = 0; base < 21; base += 4) begin
                e_dat[k] = '0;
                e_kp[k]  = '0;
                for (int l = 0; l < 4; l++) begin
                    if (base + l < 21) begin
                        e_dat[k][l*8 +: 8] = pix[f*21 + base + l];
                        e_kp[k][l]         = 1'b1;
                    end
                end
                e_lst[k] = (base + 4 >= 21);
                k++;
            end
        end

        pi  = 0;
        wi  = 0;
        cyc = 0;
        fd  = 0;
        while (wi < 12 && cyc < 2000) begin
            bus_c.pix_valid  = (pi < 42) && ($urandom_range(0, 1) == 1);
            bus_c.pix_data   = (pi < 42) ? pix[pi] : 8'h00;
            bus_c.word_ready = ($urandom_range(0, 1) == 1);
            acc = bus_c.pix_valid & bus_c.pix_ready;
            if (bus_c.word_valid && bus_c.word_ready) begin
                check($sformatf("s5_word%0d", wi),
                      {bus_c.word_data, bus_c.word_keep, bus_c.word_last},
                      {e_dat[wi], e_kp[wi], e_lst[wi]});
                wi++;
            end
            tick();
            cyc++;
            if (acc) begin
                pi++;
            end
            if (bus_c.frame_done) begin
                fd++;
            end
        end
        bus_c.pix_valid  = 1'b0;
        bus_c.word_ready = 1'b0;
        check("s5_words_seen", wi, 12);
        check("s5_pix_taken", pi, 42);
        check("s5_fd_pulses", fd, 2);
        check("s5_fcount", bus_c.frame_count, 16'd2);
        tick();
        check("s5_fd_idle", bus_c.frame_done, 1'b0);
        check("s5_empty", bus_c.word_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
